// File: rtl/risc_v_32_hazard_ctrl_if.sv
// rtl/risc_v_32_hazard_ctrl_if.sv - pipeline-side signal bundle of the hazard controller (stall_cnt when HAZARD_PERF_CNT_EN)
interface risc_v_32_hazard_ctrl_if;
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic       id_use_rs1;
    logic       id_use_rs2;
    logic [4:0] idex_rd;
    logic       idex_wreg;
    logic       idex_mem2reg;
    logic [1:0] idex_mdu_op;
    logic       ex_branch_taken;
    logic       stall_if;
    logic       stall_id;
    logic       bubble_ex;
    logic       flush_id;
    logic       hold_ex;
    logic       mdu_start;
    logic       mdu_busy;
    logic       mdu_done;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cnt;
`endif

    modport master (
        output id_rs1, id_rs2, id_use_rs1, id_use_rs2, idex_rd, idex_wreg,
               idex_mem2reg, idex_mdu_op, ex_branch_taken,
`ifdef HAZARD_PERF_CNT_EN
        input  stall_cnt,
`endif
        input  stall_if, stall_id, bubble_ex, flush_id, hold_ex,
               mdu_start, mdu_busy, mdu_done
    );

    modport slave (
        input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, idex_rd, idex_wreg,
               idex_mem2reg, idex_mdu_op, ex_branch_taken,
`ifdef HAZARD_PERF_CNT_EN
        output stall_cnt,
`endif
        output stall_if, stall_id, bubble_ex, flush_id, hold_ex,
               mdu_start, mdu_busy, mdu_done
    );
endinterface

// File: rtl/risc_v_32_hazard_ctrl.sv
// rtl/risc_v_32_hazard_ctrl.sv - RV32IM load-use/MDU/branch sequencer; optional stall counter via HAZARD_PERF_CNT_EN
module risc_v_32_hazard_ctrl #(
    parameter int MUL_CYCLES = 2,
    parameter int DIV_CYCLES = 32
) (
    input  logic                     clk,
    input  logic                     clrn,
    risc_v_32_hazard_ctrl_if.slave   hz
);
    localparam logic [7:0] MUL_N = MUL_CYCLES[7:0];
    localparam logic [7:0] DIV_N = DIV_CYCLES[7:0];

    typedef enum logic {IDLE, RUN} state_t;

    state_t     state, state_nx;
    logic [7:0] cnt, cnt_nx;
    logic [7:0] n_sel;
    logic       op_valid;
    logic       lu;
    logic       start_c, done_c, hold_c, busy_c;

    // Reserved op 11 behaves as no-op.
    always_comb begin
        op_valid = (hz.idex_mdu_op == 2'b01) || (hz.idex_mdu_op == 2'b10);
        n_sel    = (hz.idex_mdu_op == 2'b10) ? DIV_N : MUL_N;
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state <= IDLE;
            cnt   <= 8'd0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            IDLE: if (op_valid && n_sel != 8'd1) begin
                state_nx = RUN;
                cnt_nx   = n_sel - 8'd2;
            end
            RUN: begin
                if (cnt != 8'd0) cnt_nx = cnt - 8'd1;
                else             state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        start_c = 1'b0;
        done_c  = 1'b0;
        hold_c  = 1'b0;
        busy_c  = 1'b0;
        case (state)
            IDLE: if (op_valid) begin
                start_c = 1'b1;
                if (n_sel == 8'd1) done_c = 1'b1;
                else               hold_c = 1'b1;
            end
            RUN: begin
                busy_c = 1'b1;
                if (cnt != 8'd0) hold_c = 1'b1;
                else             done_c = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        lu = hz.idex_mem2reg && hz.idex_wreg && (hz.idex_rd != 5'd0) &&
             (((hz.idex_rd == hz.id_rs1) && hz.id_use_rs1) ||
              ((hz.idex_rd == hz.id_rs2) && hz.id_use_rs2));
    end

    // Every output is forced low while clrn is asserted, combinational ones included.
    assign hz.stall_if  = clrn && !hz.ex_branch_taken && (hold_c || lu);
    assign hz.stall_id  = clrn && !hz.ex_branch_taken && (hold_c || lu);
    assign hz.bubble_ex = clrn && (hz.ex_branch_taken || (!hold_c && lu));
    assign hz.flush_id  = clrn && hz.ex_branch_taken;
    assign hz.hold_ex   = clrn && hold_c;
    assign hz.mdu_start = clrn && start_c;
    assign hz.mdu_busy  = clrn && busy_c;
    assign hz.mdu_done  = clrn && done_c;

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn)
            stall_cnt_q <= 32'd0;
        else if (hz.stall_if && stall_cnt_q != 32'hFFFF_FFFF)
            stall_cnt_q <= stall_cnt_q + 32'd1;
    end

    assign hz.stall_cnt = stall_cnt_q;
`endif
endmodule
